// File: rtl/subleq_ctrl_fsm.sv
// Hardwired sequencer for one SUBLEQ instruction: mem[B] <= mem[B] - mem[A]; if result <= 0 then PC <= C.
// Drives datapath strobes and the memory handshake, with bus-timeout fault and halt-idiom detection.
module subleq_ctrl_fsm #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_BITS        = 5
) (
  input  logic       CLOCK,
  input  logic       RESET_bar,
  input  logic       run,
  input  logic       mem_ack,
  input  logic       alu_leq,
  input  logic       c_is_self,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] addr_sel,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_c,
  output logic       ld_x,
  output logic       ld_y,
  output logic       halted,
  output logic       fault,
  output logic       busy
);

  // state    | meaning
  // IDLE     | waiting for run
  // FETCH_A  | read mem[PC] into A, PC++
  // FETCH_B  | read mem[PC] into B, PC++
  // FETCH_C  | read mem[PC] into C, PC++
  // READ_X   | read mem[A] into X
  // READ_Y   | read mem[B] into Y
  // EXEC     | write Y - X to mem[B], latch alu_leq
  // BRANCH   | optional PC <= C, halt check, sample run
  // HALT     | halt idiom executed (absorbing)
  // FAULT    | memory timeout (absorbing)
  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_FETCH_C,
    S_READ_X,
    S_READ_Y,
    S_EXEC,
    S_BRANCH,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [1:0] SEL_PC = 2'd0;
  localparam logic [1:0] SEL_A  = 2'd1;
  localparam logic [1:0] SEL_B  = 2'd2;

  state_t             state_q, state_d;
  logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
  logic [TO_BITS-1:0] to_cnt_inc;
  logic               br_q, br_d;

  always_ff @(posedge CLOCK or negedge RESET_bar) begin
    if (!RESET_bar) begin
      state_q  <= S_IDLE;
      to_cnt_q <= '0;
      br_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      br_q     <= br_d;
    end
  end

  assign to_cnt_inc = to_cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    to_cnt_d = '0;
    br_d     = br_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = SEL_PC;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_c     = 1'b0;
    ld_x     = 1'b0;
    ld_y     = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    busy     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH_A;
      end
      S_FETCH_A: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        if (mem_ack) begin
          ld_a    = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_FETCH_B;
        end
      end
      S_FETCH_B: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        if (mem_ack) begin
          ld_b    = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_FETCH_C;
        end
      end
      S_FETCH_C: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        if (mem_ack) begin
          ld_c    = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_READ_X;
        end
      end
      S_READ_X: begin
        mem_req  = 1'b1;
        addr_sel = SEL_A;
        busy     = 1'b1;
        if (mem_ack) begin
          ld_x    = 1'b1;
          state_d = S_READ_Y;
        end
      end
      S_READ_Y: begin
        mem_req  = 1'b1;
        addr_sel = SEL_B;
        busy     = 1'b1;
        if (mem_ack) begin
          ld_y    = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = SEL_B;
        busy     = 1'b1;
        if (mem_ack) begin
          br_d    = alu_leq;
          state_d = S_BRANCH;
        end
      end
      S_BRANCH: begin
        busy = 1'b1;
        // Taken branch back onto itself is the halt idiom; skip the PC load.
        if (br_q && c_is_self) begin
          state_d = S_HALT;
        end else begin
          pc_load = br_q;
          state_d = run ? S_FETCH_A : S_IDLE;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Any state change or ack leaves the counter at zero, so each access starts fresh.
    if (mem_req && !mem_ack) begin
      if (to_cnt_inc == TO_BITS'(TIMEOUT_CYCLES)) begin
        state_d = S_FAULT;
      end else begin
        to_cnt_d = to_cnt_inc;
      end
    end
  end

endmodule

// File: doc/subleq_ctrl_fsm.md
Name: subleq_ctrl_fsm

Overview:
- Hardwired finite-state control unit for the SUBLEQ datapath. It sequences one instruction, mem[B] <= mem[B] - mem[A]; if result <= 0 then PC <= C.
- It drives the datapath register strobes and the memory handshake, and adds bus-timeout fault detection and halt detection.
- It sits between the shared memory port and the PC/operand/ALU datapath. It is pin-compatible with the datapath control bus, so it can replace the microcode sequencer.

Parameters:
- TIMEOUT_CYCLES, 16, number of cycles a memory access may wait for mem_ack before a fault is raised. Minimum value 1.
- TO_BITS, 5, width of the timeout counter. Must satisfy 2^TO_BITS > TIMEOUT_CYCLES.

Ports:
- CLOCK  input  1  single system clock; all state updates on the rising edge.
- RESET_bar  input  1  asynchronous, active-low reset.
- run  input  1  level; high lets the FSM leave IDLE.
- mem_ack  input  1  memory has completed the access this cycle; read data is valid while high.
- alu_leq  input  1  ALU result (mem[B] - mem[A]) <= 0; valid during EXEC.
- c_is_self  input  1  operand C equals the current instruction address (halt idiom).
- mem_req  output  1  memory access request.
- mem_we  output  1  1 = write, 0 = read; qualified by mem_req.
- addr_sel  output  2  memory address mux: 0 = PC, 1 = A register, 2 = B register.
- pc_inc  output  1  PC <= PC + 1.
- pc_load  output  1  PC <= C register.
- ld_a, ld_b, ld_c  output  1 each  capture the fetched operand address into A, B, C.
- ld_x, ld_y  output  1 each  capture mem[A] into X, mem[B] into Y.
- halted  output  1  sticky; the halt idiom was executed.
- fault  output  1  sticky; a memory timeout occurred.
- busy  output  1  FSM is in any state other than IDLE, HALT or FAULT.

Behaviour:
- States: IDLE, FETCH_A, FETCH_B, FETCH_C, READ_X, READ_Y, EXEC, BRANCH, HALT, FAULT.
- Reset (async, RESET_bar low):
  - state = IDLE, timeout counter = 0, branch latch = 0.
  - All outputs 0 while reset is asserted and on the first cycle after release.
  - Reset mid-instruction aborts the access immediately; mem_req drops asynchronously.
- IDLE: outputs 0. Go to FETCH_A when run = 1.
- Memory states are FETCH_A/B/C (addr_sel = 0, read), READ_X (addr_sel = 1, read), READ_Y (addr_sel = 2, read) and EXEC (addr_sel = 2, mem_we = 1).
  - mem_req is held high for every cycle spent in a memory state.
  - The state advances only on a cycle where mem_ack = 1.
- Strobes are Mealy, each a single-cycle pulse gated by mem_ack:
  - FETCH_A: ld_a and pc_inc.
  - FETCH_B: ld_b and pc_inc.
  - FETCH_C: ld_c and pc_inc.
  - READ_X: ld_x.
  - READ_Y: ld_y.
  - EXEC: no strobe.
- Addressing: PC is post-incremented, so after FETCH_C the PC points to the next instruction.
- Transition order: FETCH_A -> FETCH_B -> FETCH_C -> READ_X -> READ_Y -> EXEC -> BRANCH.
- EXEC: the datapath drives the ALU result on write data. The branch latch captures alu_leq on the mem_ack cycle.
- BRANCH (1 cycle, no mem_req):
  - Branch latch = 1 and c_is_self = 1: go to HALT, no pc_load.
  - Branch latch = 1 otherwise: pc_load = 1.
  - Branch latch = 0: no pc_load.
  - Next state when not halting: FETCH_A if run = 1, else IDLE.
  - Total latency is 7 cycles per instruction with zero-wait memory (mem_ack high on the first request cycle).
- Run deasserted mid-instruction: the current instruction completes; run is sampled only in IDLE and BRANCH.
- Timeout:
  - The counter clears on entry to each memory state and on every mem_ack. It increments on each cycle of mem_req = 1 with mem_ack = 0.
  - When it reaches TIMEOUT_CYCLES with mem_ack = 0: go to FAULT and set fault = 1.
  - mem_ack arriving on the same cycle the counter reaches the limit counts as success; no fault.
- Outputs in HALT and FAULT:
  - Both states are absorbing; only reset exits them.
  - All strobes and mem_req are 0, busy = 0.
  - HALT: halted = 1. FAULT: fault = 1.
- mem_ack outside a memory state is ignored.
- addr_sel = 0 in non-memory states.
- At most one of pc_inc and pc_load is high in any cycle.

Test Plan:
- Zero-wait memory, run = 1, instruction A = 10, B = 11, C = 20, mem[10] = 3, mem[11] = 5 -> mem[11] = 2, alu_leq = 0, no pc_load, PC = 3, next FETCH_A 7 cycles after the first.
- Same instruction with mem[10] = 5, mem[11] = 5 -> alu_leq = 1, pc_load pulses in BRANCH, PC = 20.
- Branch taken with c_is_self = 1 -> HALT, halted = 1, mem_req stays 0 for 20 cycles.
- mem_ack delayed 3 cycles in READ_X -> mem_req is held 4 cycles, ld_x is a single pulse, no fault.
- mem_ack withheld in FETCH_B with TIMEOUT_CYCLES = 16 -> fault = 1 after 16 wait cycles, state stays FAULT.
- RESET_bar pulsed low during EXEC -> mem_req drops immediately, all outputs 0, IDLE; with run = 1 after release, FETCH_A with PC-sourced address on the next cycle.
